// File: rtl/adc_pkg.sv
// Shared types and constants for the ADC word-alignment training controller.
package adc_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RST_SERDES,
      ST_SETTLE,
      ST_CHECK,
      ST_SLIP,
      ST_LOCKED,
      ST_FAIL
   } align_state_t;

   localparam logic [15:0] ADC_TRAIN_PATTERN = 16'hA5C3;
   localparam int          ERR_W             = 8;

endpackage

// File: rtl/adc_pattern_check.sv
// Registered training-word comparator with a consecutive-match counter.
module adc_pattern_check import adc_pkg::*; #(
   parameter logic [15:0] PATTERN   = ADC_TRAIN_PATTERN,
   parameter int          MATCH_LEN = 16
) (
   input  logic        gclk,
   input  logic        grst_n,
   input  logic        clr,
   input  logic        en,
   input  logic [15:0] d_in,
   output logic        match_done,
   output logic        mismatch
);

   localparam int MW = $clog2(MATCH_LEN + 1);

   logic [MW-1:0] cnt;
   logic          hit;

   assign hit = (d_in == PATTERN);

   // Flags only live for the cycle after a sampled word, so stale results never leak across states.
   always_ff @(posedge gclk or negedge grst_n) begin
      if (!grst_n) begin
         cnt        <= '0;
         match_done <= 1'b0;
         mismatch   <= 1'b0;
      end else if (clr || !en) begin
         match_done <= 1'b0;
         mismatch   <= 1'b0;
         if (clr) cnt <= '0;
      end else begin
         mismatch   <= !hit;
         match_done <= hit && (cnt == MW'(MATCH_LEN - 1));
         if (!hit)                        cnt <= '0;
         else if (cnt != MW'(MATCH_LEN)) cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/adc_align_ctrl.sv
// Word-alignment training controller: serdes reset/CE sequencing, bitslip search,
// lock detection and post-lock pattern error counting, all in the CLKDIV domain.
module adc_align_ctrl import adc_pkg::*; #(
   parameter logic [15:0] PATTERN       = ADC_TRAIN_PATTERN,
   parameter int          RST_CYCLES    = 4,
   parameter int          SETTLE_CYCLES = 4,
   parameter int          MATCH_LEN     = 16,
   parameter int          SLIP_RANGE    = 8
) (
   input  logic                          CLKDIV,
   input  logic                          RST_N,
   input  logic                          start,
   input  logic                          mon_en,
   input  logic [15:0]                   d_in,
   output logic                          serdes_rst,
   output logic                          serdes_ce,
   output logic                          bitslip,
   output logic                          busy,
   output logic                          locked,
   output logic                          fail,
   output logic [$clog2(SLIP_RANGE)-1:0] slip_count,
   output logic [ERR_W-1:0]              err_count
);

   localparam int SLIP_W  = $clog2(SLIP_RANGE);
   localparam int CNT_MAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   align_state_t      state, state_nx;
   logic [CNT_W-1:0]  cnt, cnt_nx;
   logic [SLIP_W-1:0] slip_nx;
   logic [ERR_W-1:0]  err_nx;
   logic              start_ok, chk_clr, chk_en, match_done, mismatch;

   assign chk_en = (state == ST_CHECK);

   adc_pattern_check #(
      .PATTERN   (PATTERN),
      .MATCH_LEN (MATCH_LEN)
   ) u_chk (
      .gclk       (CLKDIV),
      .grst_n     (RST_N),
      .clr        (chk_clr),
      .en         (chk_en),
      .d_in       (d_in),
      .match_done (match_done),
      .mismatch   (mismatch)
   );

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      slip_nx  = slip_count;
      err_nx   = err_count;
      chk_clr  = 1'b0;
      start_ok = start && (state == ST_IDLE || state == ST_LOCKED || state == ST_FAIL);
      case (state)
         ST_RST_SERDES: begin
            if (cnt == CNT_W'(RST_CYCLES - 1)) begin
               state_nx = ST_SETTLE;
               cnt_nx   = '0;
            end else cnt_nx = cnt + 1'b1;
         end
         ST_SETTLE: begin
            if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
               state_nx = ST_CHECK;
               cnt_nx   = '0;
            end else cnt_nx = cnt + 1'b1;
         end
         ST_CHECK: begin
            if (match_done) state_nx = ST_LOCKED;
            else if (mismatch) begin
               if (slip_count == SLIP_W'(SLIP_RANGE - 1)) state_nx = ST_FAIL;
               else begin
                  state_nx = ST_SLIP;
                  slip_nx  = slip_count + 1'b1;
               end
            end
         end
         ST_SLIP: begin
            state_nx = ST_SETTLE;
            cnt_nx   = '0;
            chk_clr  = 1'b1;
         end
         ST_LOCKED: begin
            if (mon_en && d_in != PATTERN && err_count != '1) err_nx = err_count + 1'b1;
         end
         default: ;
      endcase
      // A new run overrides any same-cycle error increment.
      if (start_ok) begin
         state_nx = ST_RST_SERDES;
         cnt_nx   = '0;
         slip_nx  = '0;
         err_nx   = '0;
         chk_clr  = 1'b1;
      end
   end

   always_ff @(posedge CLKDIV or negedge RST_N) begin
      if (!RST_N) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         serdes_rst <= 1'b1;
         serdes_ce  <= 1'b0;
         bitslip    <= 1'b0;
         busy       <= 1'b0;
         locked     <= 1'b0;
         fail       <= 1'b0;
         slip_count <= '0;
         err_count  <= '0;
      end else begin
         state      <= state_nx;
         cnt        <= cnt_nx;
         serdes_rst <= (state_nx == ST_IDLE) || (state_nx == ST_RST_SERDES);
         serdes_ce  <= !((state_nx == ST_IDLE) || (state_nx == ST_RST_SERDES));
         bitslip    <= (state_nx == ST_SLIP);
         busy       <= state_nx inside {ST_RST_SERDES, ST_SETTLE, ST_CHECK, ST_SLIP};
         locked     <= (state_nx == ST_LOCKED);
         fail       <= (state_nx == ST_FAIL);
         slip_count <= slip_nx;
         err_count  <= err_nx;
      end
   end

endmodule

// File: tb/tb_adc_align_ctrl.sv
// Directed bench for adc_align_ctrl with a rotating-lane source model.
module tb_adc_align_ctrl;

   localparam logic [15:0] PAT = 16'hA5C3;

   logic        CLKDIV, RST_N, start, mon_en;
   logic [15:0] d_in;
   logic        serdes_rst, serdes_ce, bitslip, busy, locked, fail;
   logic [2:0]  slip_count;
   logic [7:0]  err_count;

   int          n_chk, n_pass;
   int          mode, bs_cnt, min_gap, last_bs, tcyc;
   logic        corrupt;
   logic [2:0]  rs;

   adc_align_ctrl dut (
      .CLKDIV     (CLKDIV),
      .RST_N      (RST_N),
      .start      (start),
      .mon_en     (mon_en),
      .d_in       (d_in),
      .serdes_rst (serdes_rst),
      .serdes_ce  (serdes_ce),
      .bitslip    (bitslip),
      .busy       (busy),
      .locked     (locked),
      .fail       (fail),
      .slip_count (slip_count),
      .err_count  (err_count)
   );

   initial CLKDIV = 1'b0;
   always #5 CLKDIV = ~CLKDIV;

   function automatic logic [7:0] rotl8(input logic [7:0] x, input logic [2:0] s);
      logic [15:0] t;
      t = {x, x} << s;
      return t[15:8];
   endfunction

   // Both lanes start 3 bits off; each bitslip removes one bit of rotation.
   assign rs = 3'(3 - bs_cnt);

   always_comb begin
      case (mode)
         0:       d_in = PAT;
         1:       d_in = {rotl8(PAT[15:8], rs), rotl8(PAT[7:0], rs)};
         default: d_in = 16'h1234;
      endcase
      if (corrupt) d_in = 16'h0000;
   end

   always @(negedge CLKDIV) begin
      tcyc = tcyc + 1;
      if (bitslip) begin
         if (bs_cnt > 0 && (tcyc - last_bs) < min_gap) min_gap = tcyc - last_bs;
         last_bs = tcyc;
         bs_cnt  = bs_cnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      else n_pass++;
   endtask

   task automatic cyc(input int k);
      repeat (k) @(negedge CLKDIV);
   endtask

   task automatic do_start();
      start = 1'b1;
      @(negedge CLKDIV);
      start = 1'b0;
   endtask

   task automatic wait_done(input int n0, input int lim, output int n);
      n = n0;
      while (!(locked || fail) && n < lim) begin
         @(negedge CLKDIV);
         n++;
      end
   endtask

   initial begin
      int n;
      n_chk = 0; n_pass = 0; tcyc = 0; last_bs = 0; min_gap = 1000; bs_cnt = 0;
      RST_N = 1'b1; start = 1'b0; mon_en = 1'b0; mode = 0; corrupt = 1'b0;
      #2 RST_N = 1'b0;
      #20;
      chk("rst_serdes_rst", serdes_rst, 1);
      chk("rst_ce", serdes_ce, 0);
      chk("rst_bitslip", bitslip, 0);
      chk("rst_busy", busy, 0);
      chk("rst_locked", locked, 0);
      chk("rst_fail", fail, 0);
      chk("rst_slip", slip_count, 0);
      chk("rst_err", err_count, 0);
      @(negedge CLKDIV) RST_N = 1'b1;
      cyc(3);
      chk("idle_busy", busy, 0);

      // aligned source: 4 reset cycles, then lock after 4+4+16+1
      do_start();
      chk("t1_rst_on", serdes_rst, 1);
      chk("t1_busy", busy, 1);
      chk("t1_ce_off", serdes_ce, 0);
      cyc(3);
      chk("t1_rst_4th", serdes_rst, 1);
      cyc(1);
      chk("t1_rst_off", serdes_rst, 0);
      chk("t1_ce_on", serdes_ce, 1);
      wait_done(4, 100, n);
      chk("t1_latency", n, 25);
      chk("t1_locked", locked, 1);
      chk("t1_slip", slip_count, 0);
      chk("t1_no_bitslip", bs_cnt, 0);
      chk("t1_busy_lock", busy, 0);

      // error counting saturates
      mon_en = 1'b1; corrupt = 1'b1;
      cyc(10);
      chk("t4_err10", err_count, 10);
      cyc(290);
      chk("t4_err_sat", err_count, 255);
      chk("t4_still_locked", locked, 1);
      corrupt = 1'b0;
      cyc(2);
      chk("t4_err_hold", err_count, 255);

      // restart from LOCKED clears the count
      do_start();
      chk("t6_err_clr", err_count, 0);
      wait_done(0, 100, n);
      chk("t6_relock", locked, 1);
      corrupt = 1'b1;
      cyc(5);
      chk("t6_err5", err_count, 5);
      do_start();
      corrupt = 1'b0;
      chk("t6_start_wins", err_count, 0);
      chk("t6_start_busy", busy, 1);
      wait_done(0, 100, n);
      chk("t6_lock2", locked, 1);

      // mon_en low: no counting
      mon_en = 1'b0; corrupt = 1'b1;
      cyc(300);
      chk("t4_nomon", err_count, 0);
      corrupt = 1'b0;

      // start while busy is ignored
      do_start();
      cyc(5);
      start = 1'b1;
      cyc(1);
      start = 1'b0;
      chk("t6_ign_rst", serdes_rst, 0);
      chk("t6_ign_busy", busy, 1);
      wait_done(6, 100, n);
      chk("t6_ign_latency", n, 25);

      // rotated lanes: three bitslips to align
      mode = 1; bs_cnt = 0; min_gap = 1000;
      do_start();
      wait_done(0, 400, n);
      chk("t2_locked", locked, 1);
      chk("t2_slip", slip_count, 3);
      chk("t2_pulses", bs_cnt, 3);
      chk("t2_gap_ge5", min_gap >= 5, 1);

      // reset during SETTLE after two slips
      bs_cnt = 0;
      do_start();
      n = 0;
      while (bs_cnt < 2 && n < 200) begin
         cyc(1);
         n++;
      end
      chk("t5_two_slips", bs_cnt, 2);
      cyc(2);
      RST_N = 1'b0;
      #1;
      chk("t5_serdes_rst", serdes_rst, 1);
      chk("t5_ce", serdes_ce, 0);
      chk("t5_busy", busy, 0);
      chk("t5_slip", slip_count, 0);
      chk("t5_locked", locked, 0);
      @(negedge CLKDIV) RST_N = 1'b1;
      cyc(40);
      chk("t5_no_slip", bs_cnt, 2);
      chk("t5_idle", busy, 0);
      bs_cnt = 0;
      do_start();
      wait_done(0, 400, n);
      chk("t5_resume_lock", locked, 1);
      chk("t5_resume_slip", slip_count, 3);

      // never matching: seven slips then FAIL
      mode = 2; bs_cnt = 0;
      do_start();
      wait_done(0, 400, n);
      chk("t3_fail", fail, 1);
      chk("t3_locked", locked, 0);
      chk("t3_busy", busy, 0);
      chk("t3_slip", slip_count, 7);
      chk("t3_pulses", bs_cnt, 7);
      mode = 0; bs_cnt = 0;
      do_start();
      chk("t3_fail_clr", fail, 0);
      chk("t3_busy_again", busy, 1);
      wait_done(0, 100, n);
      chk("t3_relock_lat", n, 25);
      chk("t3_relock", locked, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/adc_align_ctrl.md
Name: adc_align_ctrl

Overview:
- Word-alignment training controller for the two-lane ADC capture path.
- Sequences deserializer reset and clock-enable, then issues bitslip pulses until the assembled 16-bit word equals the ADC's training pattern.
- After alignment, reports lock and counts pattern errors while the ADC is still in test-pattern mode.
- Runs entirely in the CLKDIV domain, alongside the capture block whose RST, CE, bitslip and d_out it drives or consumes.

Parameters:
PATTERN, 16'hA5C3, expected aligned training word.
RST_CYCLES, 4, CLKDIV cycles serdes_rst is held high per training run (>=1).
SETTLE_CYCLES, 4, cycles waited after CE enable or after each bitslip before checking (>=2).
MATCH_LEN, 16, consecutive matching words required to declare lock (>=1).
SLIP_RANGE, 8, bit positions per lane (deserialization factor).

Ports:
CLKDIV  in  1  word clock; the block's only clock.
RST_N  in  1  asynchronous active-low reset.
start  in  1  single-cycle training request.
mon_en  in  1  enables error counting while LOCKED.
d_in  in  16  assembled word from the capture block.
serdes_rst  out  1  reset to the deserializers, active high.
serdes_ce  out  1  clock enable to the deserializers.
bitslip  out  1  single-cycle bitslip pulse, shared by both lanes.
busy  out  1  high in every state except IDLE, LOCKED and FAIL.
locked  out  1  alignment achieved.
fail  out  1  no alignment found after SLIP_RANGE positions.
slip_count  out  $clog2(SLIP_RANGE)  bitslips issued in the current run.
err_count  out  8  saturating count of mismatches seen while LOCKED.

Behaviour:
- Reset (async, RST_N low): state=IDLE, serdes_rst=1, serdes_ce=0, bitslip=0, busy=0, locked=0, fail=0, slip_count=0, err_count=0. Deassertion of RST_N is synchronised externally.
- States: IDLE, RST_SERDES, SETTLE, CHECK, SLIP, LOCKED, FAIL. All outputs are registered.
- IDLE/LOCKED/FAIL, start=1 -> RST_SERDES on the next edge:
  - clears slip_count, err_count, locked and fail;
  - serdes_rst=1, serdes_ce=0 for exactly RST_CYCLES cycles.
- Exit RST_SERDES: serdes_rst=0, serdes_ce=1 -> SETTLE. serdes_ce stays 1 until the next RST_SERDES.
- SETTLE: counts SETTLE_CYCLES cycles, d_in ignored -> CHECK.
- CHECK: compares d_in against PATTERN every cycle; a match counter tracks consecutive matches.
  - Match counter reaches MATCH_LEN -> LOCKED; locked=1 on the following cycle.
  - Any mismatch: if slip_count==SLIP_RANGE-1 -> FAIL (fail=1). Otherwise -> SLIP.
- SLIP: bitslip=1 for exactly one cycle, slip_count+1, match counter cleared -> SETTLE.
  - Bitslip pulses are therefore separated by at least SETTLE_CYCLES+1 cycles.
- LOCKED: when mon_en=1 and d_in!=PATTERN, err_count increments. It saturates at 255 and never wraps. State does not change.
- FAIL: holds fail=1, busy=0 until start.
- start while busy=1 is ignored; no restart mid-run.
- start and a mismatch in the same LOCKED cycle: start wins, err_count becomes 0 with no increment.
- RST_N asserted mid-run: immediate return to the reset values. Training resumes only on a new start.
- Lock at slip_count=0 with no bitslip issued is legal.

Decomposition:
- Package adc_pkg holds:
  - the align_state_t enum;
  - the default training pattern constant ADC_TRAIN_PATTERN;
  - the err_count width constant.
- One sub-module: adc_pattern_check. It holds the registered comparator and the consecutive-match counter, with clear and enable inputs, a match_done output and a mismatch output.

Test Plan:
- Aligned source (d_in=16'hA5C3 always), start -> serdes_rst high 4 cycles; locked=1 with slip_count=0; bitslip never pulses; total latency 4+4+16+1 cycles.
- Source model rotating both lanes by 3 bits, bitslip advancing the rotation -> exactly 3 bitslip pulses, each >=5 cycles apart; locked=1; slip_count=3.
- Source never matches -> 7 bitslip pulses, then fail=1, locked=0, busy=0, slip_count=7; a later start clears fail.
- LOCKED with mon_en=1 and 300 corrupted words -> err_count=255 (saturated). The same stimulus with mon_en=0 -> err_count stays 0.
- RST_N pulsed low during SETTLE after 2 slips -> all outputs at reset values immediately; no bitslip until a new start.
- start pulsed while busy -> ignored (no restart of serdes_rst). start in the same cycle as a LOCKED mismatch -> err_count=0.
